// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment definitions: segment bit positions and the hex font.
// The font is reused by the keypad debug/echo logic.
package seg7_scan_driver_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high glyphs, {g,f,e,d,c,b,a}, indexed by nibble value
  localparam logic [0:15][6:0] FONT = {
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return FONT[nib];
  endfunction

endpackage

// File: rtl/seg7_lzb.sv
// Leading-zero blank mask: digit i (i >= 1) blanks while it and every
// digit above it hold zero. Digit 0 always shows.
module seg7_lzb
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [DIGITS-1:0][3:0] data,
  input  logic                   lz,
  output logic [DIGITS-1:0]      blank
);

  logic zero;

  always_comb begin
    blank = '0;
    zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero     = zero & (data[i] == 4'h0);
      blank[i] = lz & zero;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver with frame-synchronous value update,
// leading-zero blanking and dead time between digit slots.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 1024,
  parameter int DEAD           = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digits,
  output logic                  frame_start
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(DIGITS);

  localparam logic [6:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  typedef struct packed {
    logic [DIGITS-1:0][3:0] data;
    logic [DIGITS-1:0]      dpm;
    logic                   lz;
  } disp_t;

  disp_t           shadow;
  disp_t           act;
  logic            pending;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic            wrap;
  logic            last;
  logic            xfer;
  logic            show;
  logic [DIGITS-1:0] blank;
  logic [6:0]      glyph;

  assign wrap = (cnt == CW'(PRESCALE - 1));
  assign last = (idx == IW'(DIGITS - 1));
  assign xfer = wrap & last;
  assign show = (cnt >= CW'(DEAD));

  seg7_lzb #(
    .DIGITS(DIGITS)
  ) u_lzb (
    .data  (act.data),
    .lz    (act.lz),
    .blank (blank)
  );

  assign glyph = blank[idx] ? 7'h00 : hex_to_seg(act.data[idx]);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      shadow      <= '0;
      act         <= '0;
      frame_start <= 1'b0;
      digits      <= DIG_OFF;
      segments    <= SEG_OFF;
      dp          <= DP_OFF;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap)
        idx <= last ? '0 : idx + 1'b1;
      frame_start <= xfer;
      // Copy only at the frame boundary so a frame never tears
      if (xfer && pending)
        act <= shadow;
      if (load) begin
        shadow  <= {data, dp_mask, blank_lz};
        pending <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
      if (show) begin
        digits   <= DIG_OFF ^ (DIGITS'(1) << idx);
        segments <= SEG_OFF ^ glyph;
        dp       <= DP_OFF ^ act.dpm[idx];
      end else begin
        digits   <= DIG_OFF;
        segments <= SEG_OFF;
        dp       <= DP_OFF;
      end
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Output-side counterpart of the keypad scanner. The keypad block time-multiplexes columns and reads rows; this block time-multiplexes digit enables and drives the segment lines of a common-segment 7-segment display.
- It takes a hex value from the calculator core through a load strobe and refreshes the display continuously.
- It applies leading-zero blanking, drives decimal points, and inserts anti-ghosting dead time between digit slots.

Parameters:
- DIGITS, 4, number of display digits (2..8).
- PRESCALE, 1024, clocks per digit slot (must be > DEAD).
- DEAD, 16, clocks at the start of each slot with all digits off (must be >= 1).
- SEG_ACTIVE_LOW, 1, 1 = segment and dp outputs inverted.
- DIG_ACTIVE_LOW, 1, 1 = digit enable outputs inverted.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures data, dp_mask and blank_lz.
- data  in  4*DIGITS  hex nibbles; nibble 0 = rightmost digit.
- dp_mask  in  DIGITS  decimal point per digit; bit i = digit i.
- blank_lz  in  1  enable leading-zero blanking.
- segments  out  7  {g,f,e,d,c,b,a}; segments[0] = a.
- dp  out  1  decimal point of the currently active digit.
- digits  out  DIGITS  one-hot digit enable; bit i = digit i.
- frame_start  out  1  one-cycle pulse when slot 0 begins.

Behaviour:
- Counters:
  - cnt runs 0..PRESCALE-1 and wraps.
  - idx runs 0..DIGITS-1; it increments when cnt wraps, and wraps DIGITS-1 -> 0.
- Slot phases:
  - cnt < DEAD: DEAD phase. All digits inactive, segments and dp at their inactive level.
  - Otherwise: SHOW phase. Digit idx is active with its glyph.
- Register stages:
  - All outputs are registered, one stage after cnt/idx.
  - After reset deasserts, cnt = k on the k-th edge. digits[0] first goes active on the edge DEAD+1 clocks after the reset release.
- Shadow and active registers:
  - When load = 1, data, dp_mask and blank_lz are captured into shadow registers and a pending flag is set.
  - When cnt wraps with idx = DIGITS-1 (entering slot 0) and pending = 1: shadow is copied to active and pending clears. This prevents mid-frame tearing.
  - frame_start pulses on the same edge, whether or not a copy occurs.
- Load at the transfer edge: if load coincides with the transfer edge, the transfer uses the previous shadow contents. The new value is captured and pending stays set, so it is shown on the next frame.
- Back-to-back loads: the last load before a transfer wins. There is no queueing.
- Leading-zero blanking:
  - Digit i (i >= 1) is blank when active blank_lz = 1 and active nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blank digit still has its enable active, with all segments off.
  - dp_mask is honoured on blank digits.
- Font (active-high):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07.
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
  - When SEG_ACTIVE_LOW = 1, segments and dp are inverted.
- Digit polarity: digits is inverted when DIG_ACTIVE_LOW = 1.
- Reset values:
  - cnt = 0, idx = 0, pending = 0, shadow = 0, active = 0.
  - frame_start = 0.
  - digits, segments and dp all at their inactive level.
- Reset mid-slot: reset aborts the slot immediately; outputs go inactive on the next edge.

Decomposition:
- Shared package holds:
  - the FONT constant (16 x 7 bits);
  - segment bit index localparams (SEG_A..SEG_G);
  - a function hex_to_seg(nibble).
- The font function is shared with the keypad debug/echo logic.
- One natural sub-module, seg7_lzb: combinational leading-zero mask from active data and blank_lz, producing a DIGITS-bit blank vector.
- Counters, shadow/active registers and output registers stay in the top level.

Test Plan:
All scenarios use DIGITS = 4, PRESCALE = 8, DEAD = 2, both polarities active-low.
1. Reset held for 3 cycles, then released:
   - digits = 4'b1111, segments = 7'h7F, dp = 1 throughout reset and for 2 clocks after release.
   - digits = 4'b1110 on the 3rd clock.
2. load data = 16'h12AF, blank_lz = 0, before the first frame:
   - after transfer, slot 0 shows segments = ~7'h71;
   - slot 1 shows ~7'h77, slot 2 ~7'h5B, slot 3 ~7'h06.
   - Each slot has 2 dead clocks and 6 show clocks.
3. load 16'h0005, blank_lz = 1:
   - slots 1..3 have digits active with segments = 7'h7F;
   - slot 0 shows ~7'h6D.
   - Then load 16'h0000: digit 0 shows ~7'h3F and the others are blank.
4. load 16'h1111 during slot 2:
   - display is unchanged until frame_start;
   - the new value appears from slot 0 of the next frame, never mid-frame.
   - Also assert load with 16'h2222 on the transfer edge: the display shows 1111 this frame and 2222 the next.
5. dp_mask = 4'b0100 with blank_lz = 1, data = 16'h0003:
   - dp = 0 (on) only in slot 2, although digit 2 is blank.
6. Reset asserted mid-show of slot 1:
   - next edge has all outputs inactive and pending cleared;
   - after release the display shows 0 in slot 0 (active = 0, blank_lz = 0).
